// File: rtl/hilo_div_ctrl.sv
// HI/LO register owner for the EX stage: sequences the iterative divider and takes MULT/MTHI/MTLO writes.
// Optional HILO_FWD_EN: hi_out_o/lo_out_o forward the value being written this cycle.
//
// state | meaning
// IDLE  | no divide outstanding; single-cycle HI/LO writes accepted
// BUSY  | divide running, EX stalled, waiting for result_ok / flush / watchdog
// DONE  | divide committed; EX released for one cycle so the DIV retires
module hilo_div_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        sclr_i,
    input  logic        flush_i,
    input  logic        ex_valid_i,
    input  logic [7:0]  alucontrol_i,
    input  logic [31:0] rs_data_i,
    input  logic [63:0] mul_result_i,
    input  logic        div_result_ok_i,
    input  logic [63:0] div_result_i,
    output logic        div_start_o,
    output logic        div_cancel_o,
    output logic        stall_ex_o,
    output logic [31:0] hi_out_o,
    output logic [31:0] lo_out_o
);

    localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

    localparam int CNT_W = $clog2(DIV_CYCLES + 3);
    // Last permitted BUSY cycle: the (DIV_CYCLES+2)-th one.
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(DIV_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;

    logic is_div, is_mult, is_mthi, is_mtlo, div_req, timeout;

    assign is_div  = (alucontrol_i == EXE_DIV_OP)  || (alucontrol_i == EXE_DIVU_OP);
    assign is_mult = (alucontrol_i == EXE_MULT_OP) || (alucontrol_i == EXE_MULTU_OP);
    assign is_mthi = (alucontrol_i == EXE_MTHI_OP);
    assign is_mtlo = (alucontrol_i == EXE_MTLO_OP);
    assign div_req = ex_valid_i && is_div && !flush_i;
    assign timeout = (state_q == S_BUSY) && (cnt_q == WDOG_LAST);

    always_ff @(posedge clk_i) begin
        if (sclr_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: if (div_req) state_d = S_BUSY;
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (flush_i)              state_d = S_IDLE;
                else if (div_result_ok_i) state_d = S_DONE;
                else if (timeout)         state_d = S_IDLE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Divider shares sclr, so no cancel is issued while resetting.
    always_comb begin
        div_start_o  = 1'b0;
        div_cancel_o = 1'b0;
        stall_ex_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_start_o = div_req && !sclr_i;
                stall_ex_o  = div_req && !sclr_i;
            end
            S_BUSY: begin
                stall_ex_o   = !sclr_i;
                div_cancel_o = !sclr_i && (flush_i || (timeout && !div_result_ok_i));
            end
            default: ;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (!sclr_i) begin
            if (state_q == S_BUSY) begin
                if (div_result_ok_i && !flush_i) {hi_d, lo_d} = div_result_i;
            end else if (state_q == S_IDLE && ex_valid_i && !flush_i && !stall_ex_o) begin
                if (is_mult)      {hi_d, lo_d} = mul_result_i;
                else if (is_mthi) hi_d = rs_data_i;
                else if (is_mtlo) lo_d = rs_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sclr_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

`ifdef HILO_FWD_EN
    assign hi_out_o = hi_d;
    assign lo_out_o = lo_d;
`else
    assign hi_out_o = hi_q;
    assign lo_out_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: table of single-cycle HI/LO ops plus divide sequences, with a HI/LO scoreboard.
module tb_hilo_div_ctrl;

    localparam logic [7:0] OP_MFHI  = 8'b00010000;
    localparam logic [7:0] OP_MTHI  = 8'b00010001;
    localparam logic [7:0] OP_MTLO  = 8'b00010011;
    localparam logic [7:0] OP_MULT  = 8'b00011000;
    localparam logic [7:0] OP_MULTU = 8'b00011001;
    localparam logic [7:0] OP_DIV   = 8'b00011010;
`ifdef HILO_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        sclr, flush, ex_valid, div_result_ok;
    logic [7:0]  alucontrol;
    logic [31:0] rs_data;
    logic [63:0] mul_result, div_result;
    logic        div_start, div_cancel, stall_ex;
    logic [31:0] hi_out, lo_out;

    always #5 clk = ~clk;

    hilo_div_ctrl #(.DIV_CYCLES(32)) dut (
        .clk_i(clk), .sclr_i(sclr), .flush_i(flush), .ex_valid_i(ex_valid),
        .alucontrol_i(alucontrol), .rs_data_i(rs_data), .mul_result_i(mul_result),
        .div_result_ok_i(div_result_ok), .div_result_i(div_result),
        .div_start_o(div_start), .div_cancel_o(div_cancel), .stall_ex_o(stall_ex),
        .hi_out_o(hi_out), .lo_out_o(lo_out)
    );

    typedef struct {
        logic        valid;
        logic        flsh;
        logic [7:0]  op;
        logic [31:0] rs;
        logic [63:0] mul;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    vec_t  vecs [8];
    hilo_t sb_q [$];
    int    n_total = 0;
    int    n_pass  = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        sclr = 1'b0; flush = 1'b0; ex_valid = 1'b0; div_result_ok = 1'b0;
        alucontrol = OP_MFHI; rs_data = 32'h0BAD_0BAD;
        mul_result = 64'hF0F0_F0F0_0F0F_0F0F; div_result = 64'h0000_0002_0000_0004;
    endtask

    // One idle cycle, then compare registered HI/LO against the scoreboard head.
    task automatic check_hilo(input string name);
        hilo_t e;
        idle_inputs();
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_hi"}, 64'(hi_out), 64'(e.hi));
            chk({name, "_lo"}, 64'(lo_out), 64'(e.lo));
        end
        @(posedge clk); #1;
    endtask

    task automatic run_div(input int ok_c, input int flush_c, input int sclr_c, input int hold_c,
                           input int ncyc, output int n_stall, output int n_start,
                           output int n_cancel, output int cancel_at, output int n_both,
                           output logic [31:0] hi_at_ok);
        n_stall = 0; n_start = 0; n_cancel = 0; cancel_at = -1; n_both = 0; hi_at_ok = '0;
        for (int c = 0; c < ncyc; c++) begin
            ex_valid      = (c <= hold_c);
            alucontrol    = OP_DIV;
            flush         = (c == flush_c);
            div_result_ok = (c == ok_c);
            sclr          = (c == sclr_c);
            @(negedge clk);
            if (stall_ex)   n_stall++;
            if (div_start)  n_start++;
            if (div_cancel) begin n_cancel++; cancel_at = c; end
            if (div_start && div_cancel) n_both++;
            if (c == ok_c) hi_at_ok = hi_out;
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        int st, sp, cn, ca, bo;
        logic [31:0] hok;

        vecs[0] = '{1'b1, 1'b0, OP_MTHI,  32'h1234_5678, 64'h0, 32'h1234_5678, 32'h0};
        vecs[1] = '{1'b1, 1'b0, OP_MTLO,  32'h9ABC_DEF0, 64'h0, 32'h1234_5678, 32'h9ABC_DEF0};
        vecs[2] = '{1'b1, 1'b0, OP_MULT,  32'h5555_5555, 64'h0000_0001_FFFF_FFFE, 32'h1, 32'hFFFF_FFFE};
        vecs[3] = '{1'b1, 1'b1, OP_MTLO,  32'h0000_0055, 64'h0, 32'h1, 32'hFFFF_FFFE};
        vecs[4] = '{1'b0, 1'b0, OP_MTHI,  32'h0000_0066, 64'h0, 32'h1, 32'hFFFF_FFFE};
        vecs[5] = '{1'b1, 1'b0, OP_MFHI,  32'h0000_0077, 64'h7777_7777_7777_7777, 32'h1, 32'hFFFF_FFFE};
        vecs[6] = '{1'b1, 1'b0, OP_MULTU, 32'h0,         64'hDEAD_BEEF_CAFE_F00D, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        vecs[7] = '{1'b1, 1'b0, OP_MTLO,  32'h0000_00AA, 64'h0, 32'hDEAD_BEEF, 32'h0000_00AA};

        idle_inputs();
        sclr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall", 64'(stall_ex), 64'd0);
        chk("rst_start", 64'(div_start), 64'd0);
        chk("rst_cancel", 64'(div_cancel), 64'd0);
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        @(posedge clk); #1;
        sclr = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            ex_valid = vecs[i].valid; flush = vecs[i].flsh; alucontrol = vecs[i].op;
            rs_data = vecs[i].rs; mul_result = vecs[i].mul;
            sb_q.push_back('{vecs[i].exp_hi, vecs[i].exp_lo});
            @(negedge clk);
            chk($sformatf("tbl%0d_stall", i), 64'(stall_ex), 64'd0);
            chk($sformatf("tbl%0d_start", i), 64'(div_start), 64'd0);
            chk($sformatf("tbl%0d_fwd_hi", i), 64'(hi_out), 64'(FWD ? vecs[i].exp_hi : m_hi));
            chk($sformatf("tbl%0d_fwd_lo", i), 64'(lo_out), 64'(FWD ? vecs[i].exp_lo : m_lo));
            @(posedge clk); #1;
            m_hi = vecs[i].exp_hi; m_lo = vecs[i].exp_lo;
            check_hilo($sformatf("tbl%0d", i));
        end

        // Normal divide: result_ok 33 cycles after start, DIV stays in EX through DONE.
        sb_q.push_back('{32'h2, 32'h4});
        run_div(33, -1, -1, 34, 38, st, sp, cn, ca, bo, hok);
        chk("div_stall_cycles", 64'(st), 64'd34);
        chk("div_start_pulses", 64'(sp), 64'd1);
        chk("div_cancel_pulses", 64'(cn), 64'd0);
        chk("div_fwd_hi", 64'(hok), 64'(FWD ? 32'h2 : m_hi));
        check_hilo("div");
        m_hi = 32'h2; m_lo = 32'h4;

        // Flush 10 cycles into BUSY.
        sb_q.push_back('{m_hi, m_lo});
        run_div(-1, 10, -1, 10, 14, st, sp, cn, ca, bo, hok);
        chk("flush_cancel_pulses", 64'(cn), 64'd1);
        chk("flush_cancel_cycle", 64'(ca), 64'd10);
        chk("flush_stall_cycles", 64'(st), 64'd11);
        chk("flush_both", 64'(bo), 64'd0);
        check_hilo("flush");

        // Flush and result_ok together: flush wins.
        sb_q.push_back('{m_hi, m_lo});
        run_div(5, 5, -1, 5, 8, st, sp, cn, ca, bo, hok);
        chk("flok_cancel_pulses", 64'(cn), 64'd1);
        chk("flok_cancel_cycle", 64'(ca), 64'd5);
        chk("flok_stall_cycles", 64'(st), 64'd6);
        check_hilo("flok");

        // Watchdog: no result_ok, cancel on the 34th BUSY cycle.
        sb_q.push_back('{m_hi, m_lo});
        run_div(-1, -1, -1, 34, 38, st, sp, cn, ca, bo, hok);
        chk("wdog_cancel_pulses", 64'(cn), 64'd1);
        chk("wdog_cancel_cycle", 64'(ca), 64'd34);
        chk("wdog_stall_cycles", 64'(st), 64'd35);
        chk("wdog_start_pulses", 64'(sp), 64'd1);
        check_hilo("wdog");

        // sclr mid-BUSY: no cancel, HI/LO cleared by reset.
        sb_q.push_back('{32'h0, 32'h0});
        run_div(-1, -1, 5, 5, 8, st, sp, cn, ca, bo, hok);
        chk("sclr_cancel_pulses", 64'(cn), 64'd0);
        chk("sclr_stall_cycles", 64'(st), 64'd5);
        check_hilo("sclr");
        m_hi = '0; m_lo = '0;

        // Quick divide after reset to confirm recovery.
        sb_q.push_back('{32'h2, 32'h4});
        run_div(3, -1, -1, 4, 7, st, sp, cn, ca, bo, hok);
        chk("quick_stall_cycles", 64'(st), 64'd4);
        chk("quick_start_pulses", 64'(sp), 64'd1);
        check_hilo("quick");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
